wb_fwd_pipe: RTL and testbench

Producer side of the ID-stage operand-forwarding path. Tracks each register-writing instruction through EX, MEM and WB pipeline registers and drives the three 38-bit forwarding buses `{we, waddr[4:0], data[31:0]}` that the ID-stage register file consumes. Also drives the register-file write port and raises a load-use stall request when an ID-stage operand depends on a load still in EX. Sits between ID and the EX/MEM/WB datapath of the 5-stage core.

---
 rtl/wb_fwd_pipe.sv | 107 ++++++++++
 tb/tb_wb_fwd_pipe.sv | 329 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/wb_fwd_pipe.sv
// EX/MEM/WB destination tracking for ID-stage operand forwarding.
// Drives the three forwarding buses, the RF write port and the load-use stall.
module wb_fwd_pipe (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic        flush,
  input  logic        id_valid,
  input  logic        id_rf_we,
  input  logic [4:0]  id_rf_waddr,
  input  logic        id_is_load,
  input  logic        id_ren1,
  input  logic        id_ren2,
  input  logic [4:0]  id_raddr1,
  input  logic [4:0]  id_raddr2,
  input  logic [31:0] ex_result,
  input  logic [31:0] mem_rdata,
  output logic [37:0] ex_to_id_bus,
  output logic [37:0] mem_to_id_bus,
  output logic [37:0] wb_to_id_bus,
  output logic        rf_we,
  output logic [4:0]  rf_waddr,
  output logic [31:0] rf_wdata,
  output logic        load_use_stall
);

  typedef struct packed {
    logic       valid;
    logic       we;
    logic [4:0] waddr;
    logic       is_load;
  } ex_reg_t;

  typedef struct packed {
    logic        valid;
    logic        we;
    logic [4:0]  waddr;
    logic        is_load;
    logic [31:0] data;
  } mw_reg_t;

  ex_reg_t ex_q, ex_d;
  mw_reg_t mem_q, mem_d;
  mw_reg_t wb_q, wb_d;

  logic [31:0] mem_data;
  logic        hit1;
  logic        hit2;
  logic        lus;

  assign hit1 = id_ren1 & (id_raddr1 == ex_q.waddr);
  assign hit2 = id_ren2 & (id_raddr2 == ex_q.waddr);
  assign lus  = ex_q.valid & ex_q.we & ex_q.is_load
              & (hit1 | hit2);

  assign mem_data = mem_q.is_load ? mem_rdata : mem_q.data;

  always_comb begin
    ex_d  = ex_q;
    mem_d = mem_q;
    wb_d  = wb_q;
    if (!stall) begin
      mem_d.valid   = ex_q.valid;
      mem_d.we      = ex_q.we;
      mem_d.waddr   = ex_q.waddr;
      mem_d.is_load = ex_q.is_load;
      mem_d.data    = ex_result;
      wb_d          = mem_q;
      wb_d.data     = mem_data;
      // Redirect or load-use hazard: EX takes a bubble.
      if (flush | lus) begin
        ex_d = '0;
      end else begin
        ex_d.valid   = id_valid;
        ex_d.we      = id_valid & id_rf_we
                     & (id_rf_waddr != 5'd0);
        ex_d.waddr   = id_rf_waddr;
        ex_d.is_load = id_valid & id_is_load;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ex_q  <= '0;
      mem_q <= '0;
      wb_q  <= '0;
    end else begin
      ex_q  <= ex_d;
      mem_q <= mem_d;
      wb_q  <= wb_d;
    end
  end

  assign ex_to_id_bus = {ex_q.valid & ex_q.we & ~ex_q.is_load,
                         ex_q.waddr, ex_result};
  assign mem_to_id_bus = {mem_q.valid & mem_q.we,
                          mem_q.waddr, mem_data};
  assign wb_to_id_bus = {wb_q.valid & wb_q.we,
                         wb_q.waddr, wb_q.data};

  assign rf_we          = wb_q.valid & wb_q.we;
  assign rf_waddr       = wb_q.waddr;
  assign rf_wdata       = wb_q.data;
  assign load_use_stall = lus;

endmodule

// File: tb/tb_wb_fwd_pipe.sv
// Directed bench for wb_fwd_pipe: reset, r0, load-use, flush,
// stall precedence and back-to-back forwarding.
module tb_wb_fwd_pipe;

  logic        clk;
  logic        rst;
  logic        stall;
  logic        flush;
  logic        id_valid;
  logic        id_rf_we;
  logic [4:0]  id_rf_waddr;
  logic        id_is_load;
  logic        id_ren1;
  logic        id_ren2;
  logic [4:0]  id_raddr1;
  logic [4:0]  id_raddr2;
  logic [31:0] ex_result;
  logic [31:0] mem_rdata;
  logic [37:0] ex_to_id_bus;
  logic [37:0] mem_to_id_bus;
  logic [37:0] wb_to_id_bus;
  logic        rf_we;
  logic [4:0]  rf_waddr;
  logic [31:0] rf_wdata;
  logic        load_use_stall;

  int checks;
  int failures;

  wb_fwd_pipe dut (
    .clk            (clk),
    .rst            (rst),
    .stall          (stall),
    .flush          (flush),
    .id_valid       (id_valid),
    .id_rf_we       (id_rf_we),
    .id_rf_waddr    (id_rf_waddr),
    .id_is_load     (id_is_load),
    .id_ren1        (id_ren1),
    .id_ren2        (id_ren2),
    .id_raddr1      (id_raddr1),
    .id_raddr2      (id_raddr2),
    .ex_result      (ex_result),
    .mem_rdata      (mem_rdata),
    .ex_to_id_bus   (ex_to_id_bus),
    .mem_to_id_bus  (mem_to_id_bus),
    .wb_to_id_bus   (wb_to_id_bus),
    .rf_we          (rf_we),
    .rf_waddr       (rf_waddr),
    .rf_wdata       (rf_wdata),
    .load_use_stall (load_use_stall)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [37:0] bus(
    input logic        w,
    input logic [4:0]  a,
    input logic [31:0] d
  );
    return {w, a, d};
  endfunction

  task automatic chk(
    input string       tag,
    input logic [37:0] obs,
    input logic [37:0] exp
  );
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic issue(
    input logic       we,
    input logic [4:0] wa,
    input logic       ld,
    input logic       r1,
    input logic [4:0] a1,
    input logic       r2,
    input logic [4:0] a2
  );
    id_valid    = 1'b1;
    id_rf_we    = we;
    id_rf_waddr = wa;
    id_is_load  = ld;
    id_ren1     = r1;
    id_raddr1   = a1;
    id_ren2     = r2;
    id_raddr2   = a2;
  endtask

  task automatic idle();
    id_valid    = 1'b0;
    id_rf_we    = 1'b0;
    id_rf_waddr = 5'd0;
    id_is_load  = 1'b0;
    id_ren1     = 1'b0;
    id_raddr1   = 5'd0;
    id_ren2     = 1'b0;
    id_raddr2   = 5'd0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    checks    = 0;
    failures  = 0;
    rst       = 1'b1;
    stall     = 1'b0;
    flush     = 1'b0;
    ex_result = 32'h0;
    mem_rdata = 32'h0;
    idle();

    // power-on reset
    #12;
    chk("rst_ex", ex_to_id_bus, 38'h0);
    chk("rst_mem", mem_to_id_bus, 38'h0);
    chk("rst_wb", wb_to_id_bus, 38'h0);
    chk("rst_rfwe", rf_we, 1'b0);
    chk("rst_lus", load_use_stall, 1'b0);
    @(negedge clk);
    rst = 1'b0;

    // mid-stream reset
    issue(1'b1, 5'd2, 1'b0, 1'b0, 5'd0, 1'b0, 5'd0);
    tick();
    ex_result = 32'h9;
    idle();
    tick();
    #1;
    chk("pre_rst_mem", mem_to_id_bus, bus(1'b1, 5'd2, 32'h9));
    #1;
    rst = 1'b1;
    #1;
    chk("mid_rst_mem", mem_to_id_bus, 38'h0);
    chk("mid_rst_wb", wb_to_id_bus, 38'h0);
    chk("mid_rst_exwe", ex_to_id_bus[37], 1'b0);
    chk("mid_rst_rfwe", rf_we, 1'b0);
    ex_result = 32'h0;
    issue(1'b1, 5'd3, 1'b0, 1'b0, 5'd0, 1'b0, 5'd0);
    @(negedge clk);
    rst = 1'b0;

    // addi r3 = 5 after reset release
    tick();
    ex_result = 32'h5;
    idle();
    #1;
    chk("addi_ex", ex_to_id_bus, bus(1'b1, 5'd3, 32'h5));
    chk("addi_ex_memwe", mem_to_id_bus[37], 1'b0);
    tick();
    ex_result = 32'h0;
    #1;
    chk("addi_mem", mem_to_id_bus, bus(1'b1, 5'd3, 32'h5));
    tick();
    #1;
    chk("addi_wb", wb_to_id_bus, bus(1'b1, 5'd3, 32'h5));
    chk("addi_rf", {rf_we, rf_waddr, rf_wdata},
        bus(1'b1, 5'd3, 32'h5));

    // write to r0 is suppressed everywhere
    issue(1'b1, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 5'd0);
    tick();
    ex_result = 32'hFFFF_FFFF;
    idle();
    #1;
    chk("r0_exwe", ex_to_id_bus[37], 1'b0);
    tick();
    ex_result = 32'h0;
    #1;
    chk("r0_memwe", mem_to_id_bus[37], 1'b0);
    tick();
    #1;
    chk("r0_wbwe", wb_to_id_bus[37], 1'b0);
    chk("r0_rfwe", rf_we, 1'b0);

    // load r4, dependent reads r4 via raddr2
    issue(1'b1, 5'd4, 1'b1, 1'b0, 5'd0, 1'b0, 5'd0);
    tick();
    ex_result = 32'h100;
    issue(1'b1, 5'd5, 1'b0, 1'b1, 5'd1, 1'b1, 5'd4);
    #1;
    chk("lu_stall1", load_use_stall, 1'b1);
    chk("lu_load_exwe", ex_to_id_bus[37], 1'b0);
    tick();
    ex_result = 32'h0;
    mem_rdata = 32'hDEAD_BEEF;
    #1;
    chk("lu_stall2", load_use_stall, 1'b0);
    chk("lu_bubble_exwe", ex_to_id_bus[37], 1'b0);
    chk("lu_mem", mem_to_id_bus, bus(1'b1, 5'd4, 32'hDEAD_BEEF));
    tick();
    ex_result = 32'h55;
    mem_rdata = 32'h0;
    idle();
    #1;
    chk("lu_dep_ex", ex_to_id_bus, bus(1'b1, 5'd5, 32'h55));
    chk("lu_bubble_memwe", mem_to_id_bus[37], 1'b0);
    chk("lu_wb", wb_to_id_bus, bus(1'b1, 5'd4, 32'hDEAD_BEEF));

    // load r6 with dependent at distance 2
    issue(1'b1, 5'd6, 1'b1, 1'b0, 5'd0, 1'b0, 5'd0);
    tick();
    ex_result = 32'h200;
    issue(1'b0, 5'd0, 1'b0, 1'b1, 5'd9, 1'b0, 5'd0);
    #1;
    chk("d2_stall_a", load_use_stall, 1'b0);
    tick();
    ex_result = 32'h0;
    issue(1'b1, 5'd8, 1'b0, 1'b1, 5'd6, 1'b0, 5'd0);
    #1;
    chk("d2_stall_b", load_use_stall, 1'b0);

    // flush kills r7, older r1/r2 still commit
    issue(1'b1, 5'd1, 1'b0, 1'b0, 5'd0, 1'b0, 5'd0);
    tick();
    ex_result = 32'h11;
    issue(1'b1, 5'd2, 1'b0, 1'b0, 5'd0, 1'b0, 5'd0);
    tick();
    ex_result = 32'h22;
    issue(1'b1, 5'd7, 1'b0, 1'b0, 5'd0, 1'b0, 5'd0);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    ex_result = 32'h77;
    idle();
    #1;
    chk("fl_exwe", ex_to_id_bus[37], 1'b0);
    chk("fl_mem", mem_to_id_bus, bus(1'b1, 5'd2, 32'h22));
    chk("fl_wb", wb_to_id_bus, bus(1'b1, 5'd1, 32'h11));
    tick();
    ex_result = 32'h0;
    #1;
    chk("fl_memwe", mem_to_id_bus[37], 1'b0);
    chk("fl_rf", {rf_we, rf_waddr, rf_wdata},
        bus(1'b1, 5'd2, 32'h22));
    tick();
    #1;
    chk("fl_rfwe", rf_we, 1'b0);

    // stall for 3 cycles, flush in the middle one
    issue(1'b1, 5'd10, 1'b0, 1'b0, 5'd0, 1'b0, 5'd0);
    tick();
    ex_result = 32'hA0;
    issue(1'b1, 5'd11, 1'b0, 1'b0, 5'd0, 1'b0, 5'd0);
    stall = 1'b1;
    #1;
    chk("st_ex0", ex_to_id_bus, bus(1'b1, 5'd10, 32'hA0));
    tick();
    flush = 1'b1;
    #1;
    chk("st_ex1", ex_to_id_bus, bus(1'b1, 5'd10, 32'hA0));
    chk("st_memwe1", mem_to_id_bus[37], 1'b0);
    tick();
    flush = 1'b0;
    #1;
    chk("st_ex2", ex_to_id_bus, bus(1'b1, 5'd10, 32'hA0));
    tick();
    stall = 1'b0;
    #1;
    chk("st_ex3", ex_to_id_bus, bus(1'b1, 5'd10, 32'hA0));
    chk("st_memwe3", mem_to_id_bus[37], 1'b0);
    tick();
    ex_result = 32'hB0;
    idle();
    #1;
    chk("st_res_ex", ex_to_id_bus, bus(1'b1, 5'd11, 32'hB0));
    chk("st_res_mem", mem_to_id_bus, bus(1'b1, 5'd10, 32'hA0));
    tick();
    ex_result = 32'h0;
    #1;
    chk("st_res_mem2", mem_to_id_bus, bus(1'b1, 5'd11, 32'hB0));
    chk("st_res_wb", wb_to_id_bus, bus(1'b1, 5'd10, 32'hA0));

    // back-to-back writes to r1..r4
    issue(1'b1, 5'd1, 1'b0, 1'b0, 5'd0, 1'b0, 5'd0);
    tick();
    ex_result = 32'h1;
    issue(1'b1, 5'd2, 1'b0, 1'b0, 5'd0, 1'b0, 5'd0);
    #1;
    chk("bb1_ex", ex_to_id_bus, bus(1'b1, 5'd1, 32'h1));
    tick();
    ex_result = 32'h2;
    issue(1'b1, 5'd3, 1'b0, 1'b0, 5'd0, 1'b0, 5'd0);
    #1;
    chk("bb2_ex", ex_to_id_bus, bus(1'b1, 5'd2, 32'h2));
    chk("bb2_mem", mem_to_id_bus, bus(1'b1, 5'd1, 32'h1));
    tick();
    ex_result = 32'h3;
    issue(1'b1, 5'd4, 1'b0, 1'b0, 5'd0, 1'b0, 5'd0);
    #1;
    chk("bb3_ex", ex_to_id_bus, bus(1'b1, 5'd3, 32'h3));
    chk("bb3_mem", mem_to_id_bus, bus(1'b1, 5'd2, 32'h2));
    chk("bb3_wb", wb_to_id_bus, bus(1'b1, 5'd1, 32'h1));
    tick();
    ex_result = 32'h4;
    idle();
    #1;
    chk("bb4_ex", ex_to_id_bus, bus(1'b1, 5'd4, 32'h4));
    chk("bb4_mem", mem_to_id_bus, bus(1'b1, 5'd3, 32'h3));
    chk("bb4_rf", {rf_we, rf_waddr, rf_wdata},
        bus(1'b1, 5'd2, 32'h2));
    tick();
    ex_result = 32'h0;
    #1;
    chk("bb5_mem", mem_to_id_bus, bus(1'b1, 5'd4, 32'h4));
    chk("bb5_rf", {rf_we, rf_waddr, rf_wdata},
        bus(1'b1, 5'd3, 32'h3));
    tick();
    #1;
    chk("bb6_rf", {rf_we, rf_waddr, rf_wdata},
        bus(1'b1, 5'd4, 32'h4));
    tick();
    #1;
    chk("bb7_rfwe", rf_we, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
